// File: rtl/bch3d_64_pkg.sv
// rtl/bch3d_64_pkg.sv - shared constants, status codes and FSM state type for the bch3d_64 decoder controller
// Contents: CODE_W/DATA_W widths, STAT_* response encodings, state_t, classify() flag-to-status helper.
package bch3d_64_pkg;

    localparam int CODE_W = 79;
    localparam int DATA_W = 64;

    localparam logic [1:0] STAT_CLEAN   = 2'b00;
    localparam logic [1:0] STAT_CORR    = 2'b01;
    localparam logic [1:0] STAT_UNCORR  = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // A detection the decoder could not correct is treated like a fatal error.
    function automatic logic [1:0] classify(input logic corr, input logic detec, input logic fatal);
        if (fatal || (detec && !corr)) begin
            return STAT_UNCORR;
        end
        if (corr) begin
            return STAT_CORR;
        end
        return STAT_CLEAN;
    endfunction

endpackage

// File: rtl/bch3d_64_dec_ctrl_if.sv
// rtl/bch3d_64_dec_ctrl_if.sv - requester and decoder-side signal bundle of the decoder controller
// Signals: req_valid/req_code0/req_code1 -> req_ack/resp_data/resp_status (requesters),
//          dec_enable/dec_code -> dec_data/dec_valid/dec_err_* (decoder).
// Modports: slave = controller view, master = environment (requesters + decoder) view.
interface bch3d_64_dec_ctrl_if;
    import bch3d_64_pkg::*;

    logic [1:0]        req_valid;
    logic [0:CODE_W-1] req_code0;
    logic [0:CODE_W-1] req_code1;
    logic [1:0]        req_ack;
    logic [0:DATA_W-1] resp_data;
    logic [1:0]        resp_status;
    logic              dec_enable;
    logic [0:CODE_W-1] dec_code;
    logic [0:DATA_W-1] dec_data;
    logic              dec_valid;
    logic              dec_err_corr;
    logic              dec_err_detec;
    logic              dec_err_fatal;

    modport slave (
        input  req_valid, req_code0, req_code1,
        input  dec_data, dec_valid, dec_err_corr, dec_err_detec, dec_err_fatal,
        output req_ack, resp_data, resp_status, dec_enable, dec_code
    );

    modport master (
        output req_valid, req_code0, req_code1,
        output dec_data, dec_valid, dec_err_corr, dec_err_detec, dec_err_fatal,
        input  req_ack, resp_data, resp_status, dec_enable, dec_code
    );

endinterface

// File: rtl/bch3d_rr_arb2.sv
// rtl/bch3d_rr_arb2.sv - two-way round-robin grant with pointer update on advance
// Ports: clk, reset_n (async, active low), req[1:0], advance, served (index just completed),
//        gnt_idx (selected requester), gnt_any (some request present).
module bch3d_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic       gnt_idx,
    output logic       gnt_any
);

    logic ptr;

    assign gnt_any = |req;

    // The pointer only matters under contention; a lone request always wins.
    always_comb begin
        gnt_idx = req[1];
        if (req == 2'b11) begin
            gnt_idx = ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

endmodule

// File: rtl/bch3d_64_dec_ctrl.sv
// rtl/bch3d_64_dec_ctrl.sv - arbitrates two requesters onto one bch3d_64_dec decoder with timeout and error counters
// Ports: clk, reset_n (async, active low), bus (requester + decoder bundle, slave view),
//        cnt_clr (sync clear), cnt_corr/cnt_uncorr (saturating statistics), busy (not IDLE).
module bch3d_64_dec_ctrl
    import bch3d_64_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    bch3d_64_dec_ctrl_if.slave bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   cnt_corr,
    output logic [CNT_W-1:0]   cnt_uncorr,
    output logic               busy
);

    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic       gnt_idx;
    logic       gnt_any;
    logic       cur_idx;
    logic [7:0] tmr;

    bch3d_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (state == ST_RESP),
        .served  (cur_idx),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        bus.dec_enable = 1'b0;
        bus.req_ack    = 2'b00;
        busy           = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.dec_enable = 1'b1;
                state_nx       = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.dec_valid || (tmr == TMR_LAST)) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.req_ack = cur_idx ? 2'b10 : 2'b01;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Response registers load on the WAIT->RESP edge, so they change exactly
    // as the ack appears and hold afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_idx         <= 1'b0;
            tmr             <= 8'd0;
            bus.dec_code    <= '0;
            bus.resp_data   <= '0;
            bus.resp_status <= STAT_CLEAN;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        cur_idx      <= gnt_idx;
                        bus.dec_code <= gnt_idx ? bus.req_code1 : bus.req_code0;
                    end
                end
                ST_ISSUE: tmr <= 8'd0;
                ST_WAIT: begin
                    if (bus.dec_valid) begin
                        bus.resp_data   <= bus.dec_data;
                        bus.resp_status <= classify(bus.dec_err_corr, bus.dec_err_detec,
                                                    bus.dec_err_fatal);
                    end else begin
                        tmr <= tmr + 8'd1;
                        if (tmr == TMR_LAST) begin
                            bus.resp_data   <= '0;
                            bus.resp_status <= STAT_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (state == ST_RESP) begin
            if ((bus.resp_status == STAT_CORR) && (cnt_corr != {CNT_W{1'b1}})) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            // Both uncorrectable and timeout encodings have the top bit set.
            if (bus.resp_status[1] && (cnt_uncorr != {CNT_W{1'b1}})) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bch3d_64_dec_ctrl.sv
// tb/tb_bch3d_64_dec_ctrl.sv - scoreboard bench for bch3d_64_dec_ctrl with a behavioural decoder
module tb_bch3d_64_dec_ctrl;
    import bch3d_64_pkg::*;

    localparam int CNT_W = 2;
    localparam int TO    = 15;

    typedef struct {
        logic [1:0]  ack;
        logic [0:78] code;
        logic [0:63] data;
        logic [1:0]  st;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;
    logic             busy;

    bch3d_64_dec_ctrl_if bus ();

    bch3d_64_dec_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   en_cyc = 0;
    int   ack_cyc = 0;
    logic prev_en = 1'b0;
    exp_t sb[$];
    exp_t e_mon;

    bit   dec_mute = 1'b0;
    bit   m_corr = 1'b0;
    bit   m_detec = 1'b0;
    bit   m_fatal = 1'b0;
    logic [0:78] code_c;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [0:78] code, input logic [1:0] st);
        exp_t e;
        e.ack  = (idx == 1) ? 2'b10 : 2'b01;
        e.code = code;
        e.data = (st == STAT_TIMEOUT) ? 64'd0 : code[15:78];
        e.st   = st;
        sb.push_back(e);
    endtask

    // Holds req_valid=mask until the n-th ack, dropping it in that ack cycle.
    task automatic run(input logic [1:0] mask, input int n, input bit clr_on_last);
        int got = 0;
        int w = 0;
        bus.req_valid = mask;
        while (got < n && w < 400) begin
            @(negedge clk);
            w++;
            if (bus.req_ack != 2'b00) begin
                got++;
                if (got == n) begin
                    bus.req_valid = 2'b00;
                    if (clr_on_last) cnt_clr = 1'b1;
                end
            end
        end
        bus.req_valid = 2'b00;
        check("ack_count", got, n);
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic one(input int idx, input logic [0:78] code, input logic [1:0] st,
                       input bit c, input bit d, input bit f, input bit clr_on_last);
        m_corr = c; m_detec = d; m_fatal = f;
        if (idx == 1) bus.req_code1 = code; else bus.req_code0 = code;
        push_exp(idx, code, st);
        run((idx == 1) ? 2'b10 : 2'b01, 1, clr_on_last);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Behavioural decoder: valid for one cycle, two cycles after the enable cycle.
    initial begin
        bus.dec_valid = 1'b0;
        bus.dec_data = '0;
        bus.dec_err_corr = 1'b0;
        bus.dec_err_detec = 1'b0;
        bus.dec_err_fatal = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dec_enable && !dec_mute) begin
                code_c = bus.dec_code;
                repeat (2) @(posedge clk);
                #1;
                bus.dec_valid = 1'b1;
                bus.dec_data = code_c[15:78];
                bus.dec_err_corr = m_corr;
                bus.dec_err_detec = m_detec;
                bus.dec_err_fatal = m_fatal;
                @(posedge clk);
                #1;
                bus.dec_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.dec_enable) begin
                check("en_pulse", prev_en, 1'b0);
                if (sb.size() > 0) check("dec_code_issue", bus.dec_code, sb[0].code);
                en_cyc = cyc;
            end
            prev_en = bus.dec_enable;
            if (bus.req_ack != 2'b00) begin
                ack_cyc = cyc;
                if (sb.size() == 0) begin
                    check("spurious_ack", bus.req_ack, 2'b00);
                end else begin
                    e_mon = sb.pop_front();
                    check("ack", bus.req_ack, e_mon.ack);
                    check("resp_data", bus.resp_data, e_mon.data);
                    check("resp_status", bus.resp_status, e_mon.st);
                    check("dec_code_hold", bus.dec_code, e_mon.code);
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        bus.req_valid = 2'b00;
        bus.req_code0 = '0;
        bus.req_code1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", bus.req_ack, 2'b00);
        check("rst_en", bus.dec_enable, 1'b0);
        check("rst_data", bus.resp_data, 64'd0);
        check("rst_status", bus.resp_status, 2'b00);
        check("rst_cnt", {cnt_corr, cnt_uncorr}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single clean request
        one(0, 79'h0, STAT_CLEAN, 0, 0, 0, 0);
        check("t1_cnt", {cnt_corr, cnt_uncorr}, 0);
        one(1, 79'h7, STAT_CLEAN, 0, 0, 0, 0);

        // 2: contention, pointer now favours requester 0
        bus.req_code0 = 79'h1000;
        bus.req_code1 = 79'h50000;
        for (int i = 0; i < 4; i++) push_exp(i % 2, (i % 2) ? 79'h50000 : 79'h1000, STAT_CLEAN);
        run(2'b11, 4, 0);

        // 3: error classes
        pulse_clr();
        one(0, 79'h123, STAT_CORR, 1, 0, 0, 0);
        one(1, 79'h456, STAT_UNCORR, 0, 1, 0, 0);
        one(0, 79'h789, STAT_UNCORR, 1, 0, 1, 0);
        check("t3_corr", cnt_corr, 2'd1);
        check("t3_uncorr", cnt_uncorr, 2'd2);

        // 4: timeout, then a late dec_valid in IDLE
        dec_mute = 1'b1;
        one(1, 79'hABC, STAT_TIMEOUT, 0, 0, 0, 0);
        check("t4_latency", ack_cyc - en_cyc, TO + 1);
        check("t4_uncorr", cnt_uncorr, 2'd3);
        bus.dec_valid = 1'b1;
        bus.dec_data = 64'hDEAD;
        bus.dec_err_corr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t4_late_busy", busy, 1'b0);
        end
        bus.dec_valid = 1'b0;
        bus.dec_err_corr = 1'b0;
        check("t4_hold_status", bus.resp_status, STAT_TIMEOUT);
        check("t4_hold_corr", cnt_corr, 2'd1);
        dec_mute = 1'b0;

        // 5: saturation and clear priority
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            one(0, 79'h11 + 79'(i), STAT_CORR, 1, 0, 0, 0);
            if (i == 2) check("t5_cnt3", cnt_corr, 2'd3);
        end
        check("t5_sat", cnt_corr, 2'd3);
        one(0, 79'h99, STAT_CORR, 1, 0, 0, 1);
        check("t5_clr", {cnt_corr, cnt_uncorr}, 0);
        one(0, 79'h98, STAT_CORR, 1, 0, 0, 1);
        check("t5_clr_wins", cnt_corr, 2'd0);

        // 6: reset in WAIT
        one(0, 79'h77, STAT_UNCORR, 0, 0, 1, 0);
        check("t6_pre_uncorr", cnt_uncorr, 2'd1);
        dec_mute = 1'b1;
        bus.req_code1 = 79'h3333;
        bus.req_valid = 2'b10;
        w = 0;
        while (!bus.dec_enable && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t6_issue_seen", bus.dec_enable, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_in_wait", busy, 1'b1);
        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_ack", bus.req_ack, 2'b00);
        check("t6_cnt", {cnt_corr, cnt_uncorr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dec_mute = 1'b0;
        m_corr = 0; m_detec = 0; m_fatal = 0;
        bus.req_code0 = 79'h2222;
        bus.req_code1 = 79'h4444;
        push_exp(0, 79'h2222, STAT_CLEAN);
        push_exp(1, 79'h4444, STAT_CLEAN);
        run(2'b11, 2, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bch3d_64_dec_ctrl.md
Name: bch3d_64_dec_ctrl

Overview:
Sequencing and arbitration controller for the bch3d_64_dec decoder (79-bit codeword in, 64-bit data out, with corrected, detected and fatal flags).
- Shares one decoder instance between two requesters, for example a read port and a background scrubber.
- Grants requesters round-robin and issues one codeword at a time.
- Waits for the decoder's o_valid, bounded by a timeout, then returns data plus a 2-bit status to the granted requester.
- Keeps saturating corrected and uncorrectable error counters for software.

Parameters:
CNT_W, 16, width of each error-statistics counter
TIMEOUT, 15, maximum cycles in WAIT before declaring a timeout (1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request; level, held with its code until the matching ack
req_code0  in  79  requester 0 codeword, bit order [0:78]
req_code1  in  79  requester 1 codeword, bit order [0:78]
req_ack  out  2  one-hot, one-cycle pulse; resp_* are valid in the same cycle
resp_data  out  64  decoded data [0:63]
resp_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 timeout
dec_enable  out  1  to decoder enable
dec_code  out  79  to decoder i_code
dec_data  in  64  from decoder o_data
dec_valid  in  1  from decoder o_valid
dec_err_corr  in  1  from decoder o_err_corr
dec_err_detec  in  1  from decoder o_err_detec
dec_err_fatal  in  1  from decoder o_err_fatal
cnt_clr  in  1  synchronous clear of both counters
cnt_corr  out  CNT_W  corrected-error count
cnt_uncorr  out  CNT_W  uncorrectable plus timeout count
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer selects requester 0 first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant one and go to ISSUE.
  - If both are set, grant the requester the pointer selects.
  - Latch the granted index and its codeword into dec_code.
- ISSUE:
  - dec_enable=1 for exactly one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - dec_enable=0; dec_code stays stable from ISSUE through RESP.
  - When dec_valid=1: capture dec_data and the flags, then go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to RESP with status 11 and data 0.
- Status priority when dec_valid arrives:
  - fatal, or detec without corr → 10
  - else corr → 01
  - else → 00
- RESP:
  - req_ack[granted]=1 for one cycle, with resp_data and resp_status driven.
  - The pointer moves to the other requester.
  - Go to IDLE. Back-to-back requests therefore cost at least 4 cycles plus decoder latency.
- resp_data and resp_status hold their last values outside RESP; consumers sample only on ack.
- A requester dropping req_valid after grant does not abort the transaction; the ack is still issued.
- A dec_valid pulse outside WAIT is ignored.
- Counters:
  - Increment in the RESP cycle: cnt_corr on status 01; cnt_uncorr on status 10 or 11.
  - Both saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment: the result is 0 and that increment is lost.
- Asynchronous reset mid-transaction: return to IDLE immediately, drop any pending ack, clear the counters. Requesters must re-present.

Decomposition:
- Shared package bch3d_64_pkg holds:
  - constants CODE_W=79 and DATA_W=64
  - the status encodings STAT_CLEAN, STAT_CORR, STAT_UNCORR, STAT_TIMEOUT
  - the FSM state typedef
- One natural sub-module, bch3d_rr_arb2: 2-way round-robin grant with pointer update on an advance input.
- The decoder itself is instantiated by the parent, not inside this block.

Test Plan:
1. Single request, clean decode:
   - Stimulus: req_valid=01, req_code0=0; decoder model returns valid 2 cycles after enable with data 0 and no flags.
   - Required: req_ack=01 once, resp_status=00, resp_data=0, counters unchanged.
2. Contention:
   - Stimulus: req_valid=11 held continuously for 4 transactions, codes 79'h1000 and 79'h50000.
   - Required: acks alternate 01,10,01,10; dec_enable is a single-cycle pulse each time; dec_code matches the granted requester.
3. Error classes:
   - Stimulus: decoder flags corr, then detec-only, then fatal.
   - Required: statuses 01, 10, 10; cnt_corr=1, cnt_uncorr=2.
4. Timeout:
   - Stimulus: decoder never asserts valid.
   - Required: ack with status 11 and data 0 exactly TIMEOUT cycles after leaving ISSUE; cnt_uncorr increments; a late dec_valid is ignored.
5. Saturation and clear:
   - Stimulus: CNT_W=2, 5 corrected responses, then cnt_clr coincident with a 6th.
   - Required: cnt_corr holds at 3, then reads 0.
6. Reset mid-WAIT:
   - Stimulus: assert reset_n=0 during WAIT.
   - Required: no ack, busy=0, counters 0; the next request after release is served normally starting with requester 0.
